// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter and command sequencer in front of the SRAM core.
// One command in flight; enable is held until ready or timeout, then a done pulse returns.
module sram_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_rnw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_rnw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_enable,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t              state, state_nxt;
    logic                last, owner;
    logic                cmd_rnw;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W-1:0]   res_rdata;
    logic                res_err;
    logic [CNT_W-1:0]    count;
    logic                any_req, sel, timeout_hit;

    // Both requesting: the port that did not win last time gets the grant.
    always_comb begin
        any_req     = p0_req | p1_req;
        sel         = (p0_req & p1_req) ? ~last : p1_req;
        timeout_hit = (int'(count) >= TIMEOUT - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (mem_ready || timeout_hit) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        p0_gnt     = 1'b0;
        p1_gnt     = 1'b0;
        p0_done    = 1'b0;
        p1_done    = 1'b0;
        p0_rdata   = '0;
        p1_rdata   = '0;
        p0_err     = 1'b0;
        p1_err     = 1'b0;
        mem_enable = 1'b0;
        mem_rnw    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                p0_gnt = rst_n & any_req & ~sel;
                p1_gnt = rst_n & any_req & sel;
            end
            ISSUE: begin
                mem_enable = 1'b1;
                mem_rnw    = cmd_rnw;
                mem_addr   = cmd_addr;
                mem_wdata  = cmd_wdata;
            end
            GAP: begin
                if (owner) begin
                    p1_done  = 1'b1;
                    p1_rdata = res_rdata;
                    p1_err   = res_err;
                end else begin
                    p0_done  = 1'b1;
                    p0_rdata = res_rdata;
                    p0_err   = res_err;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            owner     <= 1'b0;
            cmd_rnw   <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            res_rdata <= '0;
            res_err   <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner     <= sel;
                    last      <= sel;
                    cmd_rnw   <= sel ? p1_rnw   : p0_rnw;
                    cmd_addr  <= sel ? p1_addr  : p0_addr;
                    cmd_wdata <= sel ? p1_wdata : p0_wdata;
                end
                ISSUE: begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    if (mem_ready) begin
                        res_rdata <= cmd_rnw ? mem_rdata : '0;
                        res_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        res_rdata <= '0;
                        res_err   <= 1'b1;
                    end
                    if (!mem_ready && count != CNT_W'(TIMEOUT))
                        count <= count + 1'b1;
                end
                GAP:     count <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table, hand sequences, and a
// transaction-level reference model driving randomized requests and core latencies.
module tb_sram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req, p0_rnw, p1_req, p1_rnw;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_enable, mem_rnw, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [29:0]   all_outs;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_rnw(p0_rnw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_rnw(p1_rnw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_enable(mem_enable), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    assign all_outs = {p0_gnt, p0_done, p0_rdata, p0_err, p1_gnt, p1_done, p1_rdata, p1_err,
                       mem_enable, mem_rnw, mem_addr, mem_wdata};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic rdy; logic [DW-1:0] mrd;
        logic g0, dn0; logic [DW-1:0] rd0; logic e0;
        logic g1, dn1; logic [DW-1:0] rd1; logic e1;
        logic en, mrnw; logic [AW-1:0] maddr; logic [DW-1:0] mwd;
    } vec_t;

    vec_t tbl[9];

    // Reference model state: requesters, and the single in-flight transaction.
    int            cyc = 0;
    bit            rq[2];
    logic          rnw_q[2];
    logic [AW-1:0] addr_q[2];
    logic [DW-1:0] wd_q[2];
    int            arr[2];
    int            lat_mode;
    bit            m_busy, m_owner, m_last, m_rnw, m_err;
    int            m_g, m_done, m_lat;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_data, m_rd;
    int            gq_port[$];
    int            gq_cyc[$];

    task automatic drive_idle();
        p0_req = 0; p0_rnw = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_rnw = 0; p1_addr = '0; p1_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        #1 check("reset outs", 64'(all_outs), 64'd0);
        @(negedge clk) check("reset hold outs", 64'(all_outs), 64'd0);
        @(posedge clk); #1 rst_n = 1;
        rq[0] = 0; rq[1] = 0;
        m_busy = 0; m_last = 1;
    endtask

    task automatic step();
        bit eg0, eg1, en_exp, dn_exp, p;
        logic [11:0] exp_dn;
        logic [15:0] exp_mem;
        if (m_busy && cyc > m_done) m_busy = 0;
        for (int i = 0; i < 2; i++) begin
            if (!rq[i] && int'($urandom_range(99)) < arr[i]) begin
                rq[i] = 1; rnw_q[i] = 1'($urandom);
                addr_q[i] = AW'($urandom); wd_q[i] = DW'($urandom);
            end else if (rq[i] && m_busy && $urandom_range(1) == 1) begin
                rnw_q[i] = 1'($urandom); addr_q[i] = AW'($urandom); wd_q[i] = DW'($urandom);
            end
        end
        p0_req = rq[0]; p0_rnw = rnw_q[0]; p0_addr = addr_q[0]; p0_wdata = wd_q[0];
        p1_req = rq[1]; p1_rnw = rnw_q[1]; p1_addr = addr_q[1]; p1_wdata = wd_q[1];
        en_exp = m_busy && cyc > m_g && cyc < m_done;
        dn_exp = m_busy && cyc == m_done;
        if (en_exp) begin
            mem_ready = (cyc == m_g + m_lat);
            mem_rdata = mem_ready ? m_data : DW'($urandom);
        end else begin
            mem_ready = 1'($urandom);
            mem_rdata = DW'($urandom);
        end
        eg0 = 0; eg1 = 0; p = 0;
        if (!m_busy && (rq[0] || rq[1])) begin
            p = (rq[0] && rq[1]) ? !m_last : rq[1];
            eg0 = !p; eg1 = p;
        end
        exp_dn = '0;
        if (dn_exp) begin
            if (m_owner) exp_dn[5:0]  = {1'b1, m_err, m_rd};
            else         exp_dn[11:6] = {1'b1, m_err, m_rd};
        end
        exp_mem = en_exp ? {1'b1, m_rnw, m_addr, m_wd} : '0;
        @(negedge clk);
        check("gnt", 64'({p0_gnt, p1_gnt}), 64'({eg0, eg1}));
        check("done", 64'({p0_done, p0_err, p0_rdata, p1_done, p1_err, p1_rdata}), 64'(exp_dn));
        check("mem", 64'({mem_enable, mem_rnw, mem_addr, mem_wdata}), 64'(exp_mem));
        if (p0_gnt) begin gq_port.push_back(0); gq_cyc.push_back(cyc); end
        if (p1_gnt) begin gq_port.push_back(1); gq_cyc.push_back(cyc); end
        if (eg0 || eg1) begin
            m_busy = 1; m_g = cyc; m_owner = p; m_last = p;
            m_rnw = rnw_q[p]; m_addr = addr_q[p]; m_wd = wd_q[p];
            if (lat_mode != 0) m_lat = lat_mode;
            else case ($urandom_range(9))
                0:       m_lat = TO + 2;
                1:       m_lat = TO;
                default: m_lat = int'($urandom_range(1, 4));
            endcase
            m_data = DW'($urandom);
            m_err  = m_lat > TO;
            m_done = m_g + (m_err ? TO : m_lat) + 1;
            m_rd   = (!m_err && m_rnw) ? m_data : '0;
            rq[p]  = 0;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          r0 w0 a0 d0 | r1 w1 a1 d1 | rdy mrd | g0 dn0 rd0 e0 | g1 dn1 rd1 e1 | en mrnw maddr mwd
        tbl[0] = '{1'b1,1'b1,10'h3A5,4'h0, 1'b0,1'b0,10'h000,4'h0, 1'b0,4'h0,
                   1'b1,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,10'h000,4'h0};
        tbl[1] = '{1'b0,1'b0,10'h000,4'h0, 1'b0,1'b0,10'h000,4'h0, 1'b0,4'h7,
                   1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0, 1'b1,1'b1,10'h3A5,4'h0};
        tbl[2] = '{1'b0,1'b0,10'h000,4'h0, 1'b0,1'b0,10'h000,4'h0, 1'b1,4'hA,
                   1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0, 1'b1,1'b1,10'h3A5,4'h0};
        tbl[3] = '{1'b0,1'b0,10'h000,4'h0, 1'b1,1'b0,10'h010,4'h5, 1'b1,4'h3,
                   1'b0,1'b1,4'hA,1'b0, 1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,10'h000,4'h0};
        tbl[4] = '{1'b0,1'b0,10'h000,4'h0, 1'b1,1'b0,10'h010,4'h5, 1'b0,4'h0,
                   1'b0,1'b0,4'h0,1'b0, 1'b1,1'b0,4'h0,1'b0, 1'b0,1'b0,10'h000,4'h0};
        tbl[5] = '{1'b0,1'b0,10'h000,4'h0, 1'b0,1'b0,10'h000,4'h0, 1'b0,4'h0,
                   1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0, 1'b1,1'b0,10'h010,4'h5};
        tbl[6] = '{1'b0,1'b0,10'h000,4'h0, 1'b0,1'b0,10'h000,4'h0, 1'b1,4'hF,
                   1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0, 1'b1,1'b0,10'h010,4'h5};
        tbl[7] = '{1'b0,1'b0,10'h000,4'h0, 1'b0,1'b0,10'h000,4'h0, 1'b0,4'h0,
                   1'b0,1'b0,4'h0,1'b0, 1'b0,1'b1,4'h0,1'b0, 1'b0,1'b0,10'h000,4'h0};
        tbl[8] = '{1'b0,1'b0,10'h000,4'h0, 1'b0,1'b0,10'h000,4'h0, 1'b0,4'h0,
                   1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,10'h000,4'h0};

        arr[0] = 0; arr[1] = 0; lat_mode = 0;
        do_reset();

        // Directed read on port 0 then write on port 1, cycle by cycle.
        for (int i = 0; i < 9; i++) begin
            p0_req = tbl[i].r0; p0_rnw = tbl[i].w0; p0_addr = tbl[i].a0; p0_wdata = tbl[i].d0;
            p1_req = tbl[i].r1; p1_rnw = tbl[i].w1; p1_addr = tbl[i].a1; p1_wdata = tbl[i].d1;
            mem_ready = tbl[i].rdy; mem_rdata = tbl[i].mrd;
            @(negedge clk);
            check($sformatf("row%0d gnt", i), 64'({p0_gnt, p1_gnt}), 64'({tbl[i].g0, tbl[i].g1}));
            check($sformatf("row%0d done", i), 64'({p0_done, p0_err, p1_done, p1_err}),
                  64'({tbl[i].dn0, tbl[i].e0, tbl[i].dn1, tbl[i].e1}));
            check($sformatf("row%0d rdata", i), 64'({p0_rdata, p1_rdata}), 64'({tbl[i].rd0, tbl[i].rd1}));
            check($sformatf("row%0d mem", i), 64'({mem_enable, mem_rnw, mem_addr, mem_wdata}),
                  64'({tbl[i].en, tbl[i].mrnw, tbl[i].maddr, tbl[i].mwd}));
            @(posedge clk); #1;
        end

        // Both ports requesting from reset with a 2-cycle core: strict alternation.
        do_reset();
        arr[0] = 100; arr[1] = 100; lat_mode = 2;
        gq_port.delete(); gq_cyc.delete();
        repeat (16) step();
        check("alt grant count", 64'(gq_port.size()), 64'd4);
        for (int i = 0; i < gq_port.size() && i < 4; i++) begin
            check("alt port", 64'(gq_port[i]), 64'(i % 2));
            if (i > 0) check("alt spacing", 64'(gq_cyc[i] - gq_cyc[i-1]), 64'd4);
        end

        // Core never ready: timeouts; then ready exactly on the last allowed cycle.
        arr[0] = 100; arr[1] = 0; lat_mode = TO + 3;
        repeat (3 * (TO + 2)) step();
        arr[0] = 0; arr[1] = 100; lat_mode = TO;
        repeat (2 * (TO + 2)) step();

        // Random traffic with mixed latencies.
        arr[0] = 40; arr[1] = 40; lat_mode = 0;
        repeat (3000) step();

        // Reset pulsed in the middle of a command.
        arr[0] = 100; arr[1] = 100; lat_mode = TO + 3;
        for (int i = 0; i < 60 && !(m_busy && cyc > m_g + 1 && cyc < m_done); i++) step();
        check("reached issue", 64'(m_busy && cyc > m_g + 1 && cyc < m_done), 64'd1);
        rq[0] = 1; rq[1] = 1;
        p0_req = 1; p1_req = 1;
        #2 rst_n = 0;
        #1 check("async reset outs", 64'(all_outs), 64'd0);
        repeat (2) @(negedge clk) check("reset no done", 64'(all_outs), 64'd0);
        @(posedge clk); #1 rst_n = 1;
        m_busy = 0; m_last = 1;
        gq_port.delete(); gq_cyc.delete();
        arr[0] = 50; arr[1] = 50; lat_mode = 0;
        step();
        check("post reset first grant", 64'(gq_port.size() > 0 ? gq_port[0] : 9), 64'd0);
        repeat (200) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port round-robin arbiter and sequencer in front of `sram_core`'s user interface. Accepts read/write commands from two independent requesters (port 0, port 1) over a req/gnt/done handshake. Issues one command at a time to the core, holding `enable` until the core's `ready`, and returns read data or a timeout error to the owning port. Sits between system-level masters (e.g. host bus and scrub/BIST engine) and the single-ported SRAM core.

## Interface
Parameters:
- `ADDR_W`, 10, address width (matches core: [9:4] row, [3:0] column)
- `DATA_W`, 4, word width
- `TIMEOUT`, 15, max cycles in ISSUE without `mem_ready` before abort (1..255)

Ports:
- `clk`  input  1  single clock, rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `pN_req`  input  1  port N (N=0,1) command request; held high until `pN_gnt`
- `pN_rnw`  input  1  1=read, 0=write; valid while `pN_req`
- `pN_addr`  input  ADDR_W  command address
- `pN_wdata`  input  DATA_W  write data
- `pN_gnt`  output  1  combinational accept; command sampled on this clock edge
- `pN_done`  output  1  one-cycle completion pulse
- `pN_rdata`  output  DATA_W  read data, valid only with `pN_done`; 0 otherwise
- `pN_err`  output  1  timeout flag, valid only with `pN_done`
- `mem_enable`  output  1  to core `enable`
- `mem_rnw`  output  1  to core `read_not_write`
- `mem_addr`  output  ADDR_W  to core `addr`
- `mem_wdata`  output  DATA_W  to core `data_in`
- `mem_rdata`  input  DATA_W  from core `data_out`
- `mem_ready`  input  1  from core `ready`

## Operation
- States: IDLE, ISSUE, GAP.
- IDLE: if any `req`, grant one port (`gnt`=1 this cycle), latch rnw/addr/wdata and owner, go ISSUE. No req: stay.
- Arbitration: `last` register holds most recent owner. Both requesting: grant port != `last`. One requesting: grant it. `last` updates on every grant.
- ISSUE: `mem_enable`=1. `mem_rnw`/`mem_addr`/`mem_wdata` driven from latched command, stable for whole state. Timeout counter increments each cycle with `mem_ready`=0.
  - `mem_ready`=1: capture `mem_rdata` if read (0 if write), err=0, go GAP.
  - Counter reaches TIMEOUT first: rdata=0, err=1, go GAP.
  - `mem_ready` and timeout in the same cycle: ready wins, err=0.
- GAP: `mem_enable`=0 (lets core FSM return idle). Registered `done` pulse to owner with captured rdata/err. Counter cleared. Go IDLE.
- `gnt`, `done` never asserted in the same cycle for the same port. Non-owner's outputs stay 0.
- `mem_*` command outputs are 0 outside ISSUE.
- Reset (any state, async): state IDLE, `last`=1 (port 0 wins first tie), counter 0, all outputs 0. In-flight command dropped without `done`; requesters reissue.

## Timing
- Req seen in IDLE at cycle t: `gnt` at t, `mem_enable` high t+1.
- Core `ready` at cycle t+k (k≥1): `mem_enable` low and `done` high at t+k+1, IDLE at t+k+2. Earliest next `gnt` at t+k+2.
- Nominal 2-cycle core (ready at t+2): 4 cycles per command, `done` at t+3.
- Timeout: `mem_enable` high exactly TIMEOUT cycles (t+1..t+TIMEOUT), `done`/`err` at t+TIMEOUT+1.
- Counter width ceil(log2(TIMEOUT+1)), saturates; never wraps.
- Request inputs sampled only in IDLE; changes during ISSUE/GAP are ignored.

## Test plan
- Port 0 read addr 0x3A5, core model returns ready at t+2 with `mem_rdata`=0xA -> `mem_addr`=0x3A5, `mem_rnw`=1 for t+1..t+2, `p0_done`=1, `p0_rdata`=0xA, `p0_err`=0 at t+3.
- Port 1 write addr 0x010 data 0x5 -> `mem_rnw`=0, `mem_wdata`=0x5 during ISSUE, `p1_done` with `p1_rdata`=0, `p0_*` all 0 throughout.
- Both ports requesting continuously from reset -> grants alternate 0,1,0,1 every 4 cycles; neither port gets two consecutive grants.
- `mem_ready` held low, TIMEOUT=15 -> `mem_enable` high 15 cycles, then `p0_done`=1, `p0_err`=1, `p0_rdata`=0; next req granted 2 cycles later.
- `mem_ready` asserted on the cycle the counter hits TIMEOUT -> `done` with `err`=0 and captured data.
- `rst_n` pulsed low mid-ISSUE -> all outputs 0 immediately, no `done`; with both ports requesting after release, port 0 granted first.
